// File: rtl/fram_req_ctrl.sv
// -----------------------------------------------------------------------------
// fram_req_ctrl
//
// Request controller sitting between a host and an FRAM access stage. The host
// issues one read or write request at a time (address + byte length). The
// controller forwards a single command to the access stage, then moves the data
// bytes in the requested direction. It finishes with a one-cycle completion
// pulse that carries a status code and a 16-bit additive checksum of the bytes
// that were moved.
//
// Status codes on done_err:
//   0 ok, 1 bad length, 2 timeout, 3 read framing error
//
// Ports
//   sys_clk, glbl_rst        : clock, synchronous active-high reset
//   req_*                    : host request (valid/ready handshake)
//   wdat_*                   : host write-byte stream into the controller
//   rdat_*                   : read-byte stream to the host (no backpressure)
//   done, done_err, done_sum : completion pulse, status and checksum
//   flash_wren/rden/addr/length, flash_ready : command port to the access stage
//   flash_wr_*               : write bytes to the access stage
//   flash_rd_*               : read bytes from the access stage
// -----------------------------------------------------------------------------
module fram_req_ctrl #(
    parameter int TO_CYCLES = 1024,
    parameter int MAX_LEN   = 4096
) (
    input  logic        sys_clk,
    input  logic        glbl_rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_len,

    input  logic [7:0]  wdat_data,
    input  logic        wdat_valid,
    output logic        wdat_ready,

    output logic [7:0]  rdat_data,
    output logic        rdat_valid,
    output logic        rdat_last,

    output logic        done,
    output logic [1:0]  done_err,
    output logic [15:0] done_sum,

    output logic        flash_wren,
    output logic        flash_rden,
    output logic [15:0] flash_addr,
    output logic [15:0] flash_length,
    input  logic        flash_ready,

    output logic [7:0]  flash_wr_data,
    output logic        flash_wr_valid,
    output logic        flash_wr_last,

    input  logic [7:0]  flash_rd_data,
    input  logic        flash_rd_valid,
    input  logic        flash_rd_last
);

    localparam int TO_W = $clog2(TO_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WDATA = 3'd2,
        WWAIT = 3'd3,
        RDATA = 3'd4,
        RWAIT = 3'd5,
        DONE  = 3'd6
    } state_t;

    // 16-bit wrapping checksum accumulation of one byte
    function automatic logic [15:0] sum_add(input logic [15:0] sum, input logic [7:0] data);
        sum_add = sum + {8'h00, data};
    endfunction

    state_t          state_r;
    state_t          state_s;

    logic            wr_r;
    logic [15:0]     byte_cnt_r;
    logic [15:0]     sum_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            framing_r;

    logic            wdat_ready_r;
    logic [7:0]      rdat_data_r;
    logic            rdat_valid_r;
    logic            rdat_last_r;
    logic            done_r;
    logic [1:0]      done_err_r;
    logic [15:0]     done_sum_r;
    logic            flash_wren_r;
    logic            flash_rden_r;
    logic [15:0]     flash_addr_r;
    logic [15:0]     flash_length_r;
    logic [7:0]      flash_wr_data_r;
    logic            flash_wr_valid_r;
    logic            flash_wr_last_r;

    logic            req_ready_s;
    logic            accept_s;
    logic            len_bad_s;
    logic            wdat_hs_s;
    logic            rd_hs_s;
    logic            byte_moved_s;
    logic [7:0]      moved_byte_s;
    logic [15:0]     cnt_inc_s;
    logic            is_last_s;
    logic            counting_s;
    logic            to_expire_s;
    logic            timeout_s;
    logic            framing_set_s;
    logic            framing_nxt_s;
    logic [15:0]     sum_nxt_s;
    logic [1:0]      done_err_s;

    assign req_ready_s   = (state_r == IDLE) && flash_ready;
    assign accept_s      = req_valid && req_ready_s;
    assign len_bad_s     = (req_len == 16'h0000) || ({1'b0, req_len} > 17'(MAX_LEN));

    // wdat_ready_r is high exactly while in WDATA, so it doubles as the state qualifier
    assign wdat_hs_s     = wdat_ready_r && wdat_valid;
    assign rd_hs_s       = (state_r == RDATA) && flash_rd_valid;
    assign byte_moved_s  = wdat_hs_s || rd_hs_s;
    assign moved_byte_s  = wdat_hs_s ? wdat_data : flash_rd_data;
    assign cnt_inc_s     = byte_cnt_r + 16'h0001;
    assign is_last_s     = (cnt_inc_s == flash_length_r);

    assign counting_s    = (state_r == WDATA) || (state_r == WWAIT) ||
                           (state_r == RDATA) || (state_r == RWAIT);
    // Expiry is judged on the cycle that would make the idle count reach TO_CYCLES;
    // a byte moved on that same cycle wins and the transfer continues.
    assign to_expire_s   = (to_cnt_r >= TO_W'(TO_CYCLES - 1));
    assign timeout_s     = counting_s && !byte_moved_s && to_expire_s;

    // Framing: last marker on the wrong byte, missing on the final byte, or any
    // byte arriving after the final one.
    assign framing_set_s = (rd_hs_s && (flash_rd_last != is_last_s)) ||
                           ((state_r == RWAIT) && flash_rd_valid);
    assign framing_nxt_s = framing_r || framing_set_s;

    // Next value of the running checksum
    always_comb begin
        sum_nxt_s = sum_r;
        if (accept_s) begin
            sum_nxt_s = 16'h0000;
        end else if (byte_moved_s) begin
            sum_nxt_s = sum_add(sum_r, moved_byte_s);
        end else begin
            sum_nxt_s = sum_r;
        end
    end

    // Next-state decode and completion status selection
    always_comb begin
        state_s    = state_r;
        done_err_s = 2'd0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (len_bad_s) begin
                        state_s    = DONE;
                        done_err_s = 2'd1;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (wr_r) begin
                    state_s = WDATA;
                end else begin
                    state_s = RDATA;
                end
            end
            WDATA: begin
                if (wdat_hs_s && is_last_s) begin
                    state_s = WWAIT;
                end else if (timeout_s) begin
                    state_s    = DONE;
                    done_err_s = 2'd2;
                end else begin
                    state_s = WDATA;
                end
            end
            WWAIT: begin
                if (flash_ready) begin
                    state_s    = DONE;
                    done_err_s = 2'd0;
                end else if (timeout_s) begin
                    state_s    = DONE;
                    done_err_s = 2'd2;
                end else begin
                    state_s = WWAIT;
                end
            end
            RDATA: begin
                if (rd_hs_s && is_last_s) begin
                    state_s = RWAIT;
                end else if (timeout_s) begin
                    state_s    = DONE;
                    done_err_s = 2'd2;
                end else begin
                    state_s = RDATA;
                end
            end
            RWAIT: begin
                if (flash_ready) begin
                    state_s    = DONE;
                    done_err_s = framing_nxt_s ? 2'd3 : 2'd0;
                end else if (timeout_s) begin
                    state_s    = DONE;
                    done_err_s = 2'd2;
                end else begin
                    state_s = RWAIT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch, byte counter, checksum and framing flag
    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            wr_r           <= 1'b0;
            flash_addr_r   <= 16'h0000;
            flash_length_r <= 16'h0000;
            byte_cnt_r     <= 16'h0000;
            sum_r          <= 16'h0000;
            framing_r      <= 1'b0;
        end else if (accept_s) begin
            wr_r           <= req_wr;
            flash_addr_r   <= req_addr;
            flash_length_r <= req_len;
            byte_cnt_r     <= 16'h0000;
            sum_r          <= 16'h0000;
            framing_r      <= 1'b0;
        end else begin
            if (byte_moved_s) begin
                byte_cnt_r <= cnt_inc_s;
            end
            sum_r     <= sum_nxt_s;
            framing_r <= framing_nxt_s;
        end
    end

    // Idle-cycle timeout counter: restarts on any byte moved and on every state change
    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if ((state_s != state_r) || byte_moved_s || !counting_s) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1'b1);
        end
    end

    // Registered command, data-path and completion outputs
    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            wdat_ready_r     <= 1'b0;
            flash_wren_r     <= 1'b0;
            flash_rden_r     <= 1'b0;
            flash_wr_data_r  <= 8'h00;
            flash_wr_valid_r <= 1'b0;
            flash_wr_last_r  <= 1'b0;
            rdat_data_r      <= 8'h00;
            rdat_valid_r     <= 1'b0;
            rdat_last_r      <= 1'b0;
            done_r           <= 1'b0;
            done_err_r       <= 2'd0;
            done_sum_r       <= 16'h0000;
        end else begin
            wdat_ready_r     <= (state_s == WDATA);
            flash_wren_r     <= accept_s && !len_bad_s && req_wr;
            flash_rden_r     <= accept_s && !len_bad_s && !req_wr;
            flash_wr_valid_r <= wdat_hs_s;
            flash_wr_last_r  <= wdat_hs_s && is_last_s;
            if (wdat_hs_s) begin
                flash_wr_data_r <= wdat_data;
            end
            rdat_valid_r     <= rd_hs_s;
            rdat_last_r      <= rd_hs_s && is_last_s;
            if (rd_hs_s) begin
                rdat_data_r <= flash_rd_data;
            end
            // DONE is only ever held for one cycle, so entering it is the pulse
            done_r <= (state_s == DONE);
            if (state_s == DONE) begin
                done_err_r <= done_err_s;
                done_sum_r <= sum_nxt_s;
            end
        end
    end

    assign req_ready      = req_ready_s;
    assign wdat_ready     = wdat_ready_r;
    assign rdat_data      = rdat_data_r;
    assign rdat_valid     = rdat_valid_r;
    assign rdat_last      = rdat_last_r;
    assign done           = done_r;
    assign done_err       = done_err_r;
    assign done_sum       = done_sum_r;
    assign flash_wren     = flash_wren_r;
    assign flash_rden     = flash_rden_r;
    assign flash_addr     = flash_addr_r;
    assign flash_length   = flash_length_r;
    assign flash_wr_data  = flash_wr_data_r;
    assign flash_wr_valid = flash_wr_valid_r;
    assign flash_wr_last  = flash_wr_last_r;

endmodule

// File: tb/tb_fram_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fram_req_ctrl
//
// Directed plus randomized bench for fram_req_ctrl. The bench plays both the
// host and the FRAM access stage. Expected results (bytes seen downstream or
// upstream, completion status, checksum, command pulse counts) are derived
// from the transfer rules with plain arithmetic on the byte arrays.
// -----------------------------------------------------------------------------
module tb_fram_req_ctrl;

    localparam int TO_CYC = 24;
    localparam int MAXL   = 4096;

    logic        sys_clk = 1'b0;
    logic        glbl_rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_len;
    logic [7:0]  wdat_data;
    logic        wdat_valid;
    logic        wdat_ready;
    logic [7:0]  rdat_data;
    logic        rdat_valid;
    logic        rdat_last;
    logic        done;
    logic [1:0]  done_err;
    logic [15:0] done_sum;
    logic        flash_wren;
    logic        flash_rden;
    logic [15:0] flash_addr;
    logic [15:0] flash_length;
    logic        flash_ready;
    logic [7:0]  flash_wr_data;
    logic        flash_wr_valid;
    logic        flash_wr_last;
    logic [7:0]  flash_rd_data;
    logic        flash_rd_valid;
    logic        flash_rd_last;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations collected by the monitor
    logic [8:0]  wr_q[$];
    logic [8:0]  rd_q[$];
    int          wren_cnt = 0;
    int          rden_cnt = 0;
    int          done_cnt = 0;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_len;

    logic [7:0]  tx_bytes [0:4095];
    logic [7:0]  rx_bytes [0:15];

    always #5 sys_clk = ~sys_clk;

    fram_req_ctrl #(.TO_CYCLES(TO_CYC), .MAX_LEN(MAXL)) dut (
        .sys_clk        (sys_clk),
        .glbl_rst       (glbl_rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .wdat_data      (wdat_data),
        .wdat_valid     (wdat_valid),
        .wdat_ready     (wdat_ready),
        .rdat_data      (rdat_data),
        .rdat_valid     (rdat_valid),
        .rdat_last      (rdat_last),
        .done           (done),
        .done_err       (done_err),
        .done_sum       (done_sum),
        .flash_wren     (flash_wren),
        .flash_rden     (flash_rden),
        .flash_addr     (flash_addr),
        .flash_length   (flash_length),
        .flash_ready    (flash_ready),
        .flash_wr_data  (flash_wr_data),
        .flash_wr_valid (flash_wr_valid),
        .flash_wr_last  (flash_wr_last),
        .flash_rd_data  (flash_rd_data),
        .flash_rd_valid (flash_rd_valid),
        .flash_rd_last  (flash_rd_last)
    );

    // Output monitor, sampled mid-cycle
    always @(negedge sys_clk) begin
        if (flash_wr_valid) wr_q.push_back({flash_wr_last, flash_wr_data});
        if (rdat_valid)     rd_q.push_back({rdat_last, rdat_data});
        if (flash_wren) begin
            wren_cnt++;
            cmd_addr = flash_addr;
            cmd_len  = flash_length;
        end
        if (flash_rden) begin
            rden_cnt++;
            cmd_addr = flash_addr;
            cmd_len  = flash_length;
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {24'h0, flash_wren, flash_rden, flash_wr_valid, flash_wr_last,
                            rdat_valid, rdat_last, done, wdat_ready}, 32'h0);
        chk({tag, "_cmd"}, {flash_addr, flash_length}, 32'h0);
        chk({tag, "_dat"}, {14'h0, flash_wr_data, rdat_data, done_err}, 32'h0);
        chk({tag, "_sum"}, {16'h0, done_sum}, 32'h0);
    endtask

    task automatic send_req(input string tag, input logic wr, input logic [15:0] addr,
                            input logic [15:0] len);
        int k;
        k = 0;
        while (!req_ready && k < 100) begin
            @(negedge sys_clk);
            k++;
        end
        chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_len   = len;
        @(negedge sys_clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < (4 * TO_CYC + 100)) begin
            @(negedge sys_clk);
            k++;
        end
        chk({tag, "_done_seen"}, {31'h0, done}, 32'h1);
        @(negedge sys_clk);
        chk({tag, "_done_one_cycle"}, {31'h0, done}, 32'h0);
    endtask

    // Host writes nsend of len bytes from tx_bytes; access stage holds flash_ready low
    // until all bytes have gone through.
    task automatic do_write(input string tag, input logic [15:0] addr, input int len,
                            input int nsend, input int maxgap);
        int w0, r0, d0, nexp, k, g;
        bit bad;
        logic [15:0] es;
        logic [1:0]  ee;
        w0 = wren_cnt; r0 = rden_cnt; d0 = done_cnt;
        wr_q.delete(); rd_q.delete();
        bad = (len == 0) || (len > MAXL);
        send_req(tag, 1'b1, addr, len[15:0]);
        if (!bad) begin
            flash_ready = 1'b0;
            for (int i = 0; i < nsend; i++) begin
                g = $urandom_range(0, maxgap);
                if (g > 0) begin
                    wdat_valid = 1'b0;
                    repeat (g) @(negedge sys_clk);
                end
                wdat_valid = 1'b1;
                wdat_data  = tx_bytes[i];
                k = 0;
                while (!wdat_ready && k < 100) begin
                    @(negedge sys_clk);
                    k++;
                end
                chk({tag, "_wdat_ready"}, {31'h0, wdat_ready}, 32'h1);
                @(negedge sys_clk);
            end
            wdat_valid = 1'b0;
            if (nsend == len) begin
                repeat ($urandom_range(0, maxgap)) @(negedge sys_clk);
                flash_ready = 1'b1;
            end
        end
        wait_done(tag);
        nexp = bad ? 0 : nsend;
        es = 16'h0;
        for (int i = 0; i < nexp; i++) es = es + {8'h00, tx_bytes[i]};
        ee = bad ? 2'd1 : ((nsend < len) ? 2'd2 : 2'd0);
        chk({tag, "_wren_pulses"}, wren_cnt - w0, bad ? 32'd0 : 32'd1);
        chk({tag, "_rden_pulses"}, rden_cnt - r0, 32'd0);
        chk({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
        if (!bad) begin
            chk({tag, "_cmd_addr"}, {16'h0, cmd_addr}, {16'h0, addr});
            chk({tag, "_cmd_len"}, {16'h0, cmd_len}, len);
        end
        chk({tag, "_nbytes"}, wr_q.size(), nexp);
        for (int i = 0; i < nexp && i < wr_q.size(); i++)
            chk({tag, "_wbyte"}, {23'h0, wr_q[i]}, {23'h0, (i == len - 1), tx_bytes[i]});
        chk({tag, "_err"}, {30'h0, done_err}, {30'h0, ee});
        chk({tag, "_sum"}, {16'h0, done_sum}, {16'h0, es});
    endtask

    // Access stage returns len bytes from rx_bytes with its last marker on byte
    // index last_pos (len or more means never); optionally one stray byte after.
    task automatic do_read(input string tag, input logic [15:0] addr, input int len,
                           input int last_pos, input bit extra, input int maxgap);
        int w0, r0, d0, nexp, g;
        bit bad;
        logic [15:0] es;
        logic [1:0]  ee;
        w0 = wren_cnt; r0 = rden_cnt; d0 = done_cnt;
        wr_q.delete(); rd_q.delete();
        bad = (len == 0) || (len > MAXL);
        send_req(tag, 1'b0, addr, len[15:0]);
        if (!bad) begin
            flash_ready = 1'b0;
            @(negedge sys_clk);
            for (int i = 0; i < len; i++) begin
                g = $urandom_range(0, maxgap);
                if (g > 0) begin
                    flash_rd_valid = 1'b0;
                    repeat (g) @(negedge sys_clk);
                end
                flash_rd_valid = 1'b1;
                flash_rd_data  = rx_bytes[i];
                flash_rd_last  = (i == last_pos);
                @(negedge sys_clk);
            end
            flash_rd_valid = 1'b0;
            flash_rd_last  = 1'b0;
            if (extra) begin
                flash_rd_valid = 1'b1;
                flash_rd_data  = 8'h5A;
                flash_rd_last  = 1'b1;
                @(negedge sys_clk);
                flash_rd_valid = 1'b0;
                flash_rd_last  = 1'b0;
            end
            repeat ($urandom_range(0, maxgap)) @(negedge sys_clk);
            flash_ready = 1'b1;
        end
        wait_done(tag);
        nexp = bad ? 0 : len;
        es = 16'h0;
        for (int i = 0; i < nexp; i++) es = es + {8'h00, rx_bytes[i]};
        ee = bad ? 2'd1 : (((last_pos != len - 1) || extra) ? 2'd3 : 2'd0);
        chk({tag, "_rden_pulses"}, rden_cnt - r0, bad ? 32'd0 : 32'd1);
        chk({tag, "_wren_pulses"}, wren_cnt - w0, 32'd0);
        chk({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
        if (!bad) chk({tag, "_cmd_addr"}, {16'h0, cmd_addr}, {16'h0, addr});
        chk({tag, "_nbytes"}, rd_q.size(), nexp);
        for (int i = 0; i < nexp && i < rd_q.size(); i++)
            chk({tag, "_rbyte"}, {23'h0, rd_q[i]}, {23'h0, (i == len - 1), rx_bytes[i]});
        chk({tag, "_err"}, {30'h0, done_err}, {30'h0, ee});
        chk({tag, "_sum"}, {16'h0, done_sum}, {16'h0, es});
    endtask

    initial begin
        int len, lp, d0;
        bit wr, ex;
        glbl_rst       = 1'b1;
        req_valid      = 1'b0;
        req_wr         = 1'b0;
        req_addr       = 16'h0;
        req_len        = 16'h0;
        wdat_data      = 8'h0;
        wdat_valid     = 1'b0;
        flash_ready    = 1'b1;
        flash_rd_data  = 8'h0;
        flash_rd_valid = 1'b0;
        flash_rd_last  = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk_reset("reset");
        glbl_rst = 1'b0;
        @(negedge sys_clk);

        // Basic write
        tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h02; tx_bytes[2] = 8'h03; tx_bytes[3] = 8'h04;
        do_write("wr4", 16'h0100, 4, 4, 2);

        // Basic read
        rx_bytes[0] = 8'hAA; rx_bytes[1] = 8'hBB; rx_bytes[2] = 8'hCC;
        do_read("rd3", 16'h0200, 3, 2, 1'b0, 2);

        // Length limits: zero and one beyond the maximum are rejected
        do_write("len0", 16'h0300, 0, 0, 0);
        do_read("len4097", 16'h0300, 4097, 0, 1'b0, 0);

        // Stray read bytes while idle are ignored
        rd_q.delete();
        flash_rd_valid = 1'b1;
        flash_rd_data  = 8'h77;
        repeat (3) @(negedge sys_clk);
        flash_rd_valid = 1'b0;
        @(negedge sys_clk);
        chk("idle_rd_ignored", rd_q.size(), 32'd0);

        // Host stalls after one byte of two -> timeout
        tx_bytes[0] = 8'h3C;
        do_write("stall", 16'h0400, 2, 1, 0);
        repeat (TO_CYC + 5) @(negedge sys_clk);
        chk("stall_wdat_ready_low", {31'h0, wdat_ready}, 32'h0);
        chk("stall_req_ready_low", {31'h0, req_ready}, 32'h0);
        chk("stall_err_held", {30'h0, done_err}, 32'h2);
        flash_ready = 1'b1;
        #1;
        chk("stall_req_ready_back", {31'h0, req_ready}, 32'h1);
        @(negedge sys_clk);

        // Early last marker on a read -> framing
        rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33;
        do_read("rd_early_last", 16'h0500, 3, 1, 1'b0, 1);
        // Missing last marker, and a stray byte after the end
        do_read("rd_no_last", 16'h0510, 3, 3, 1'b0, 1);
        do_read("rd_extra", 16'h0520, 3, 2, 1'b1, 1);

        // Reset in the middle of a read, after the second byte
        d0 = done_cnt;
        send_req("rst_mid", 1'b0, 16'h0600, 16'd3);
        flash_ready = 1'b0;
        @(negedge sys_clk);
        for (int i = 0; i < 2; i++) begin
            flash_rd_valid = 1'b1;
            flash_rd_data  = rx_bytes[i];
            @(negedge sys_clk);
        end
        flash_rd_valid = 1'b0;
        glbl_rst = 1'b1;
        @(negedge sys_clk);
        chk_reset("rst_mid");
        glbl_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_mid_req_ready_low", {31'h0, req_ready}, 32'h0);
        chk("rst_mid_no_done", done_cnt - d0, 32'd0);
        flash_ready = 1'b1;
        rx_bytes[0] = 8'h0F; rx_bytes[1] = 8'hF0; rx_bytes[2] = 8'h55;
        do_read("after_rst", 16'h0610, 3, 2, 1'b0, 1);

        // Largest legal write, back to back; checksum wraps
        for (int i = 0; i < 4096; i++) tx_bytes[i] = 8'(i);
        do_write("wr_max", 16'h0000, 4096, 4096, 0);
        for (int i = 0; i < 300; i++) tx_bytes[i] = 8'hFF;
        do_write("wr_wrap", 16'h1000, 300, 300, 0);

        // Randomized mix
        for (int t = 0; t < 20; t++) begin
            wr  = $urandom_range(0, 1);
            len = $urandom_range(1, 8);
            if (wr) begin
                for (int i = 0; i < len; i++) tx_bytes[i] = 8'($urandom);
                do_write("rnd_wr", 16'($urandom), len, len, 4);
            end else begin
                for (int i = 0; i < len; i++) rx_bytes[i] = 8'($urandom);
                lp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len - 1;
                ex = ($urandom_range(0, 5) == 0);
                do_read("rnd_rd", 16'($urandom), len, lp, ex, 4);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fram_req_ctrl.md
FRAM_REQ_CTRL -- requirements
Module: fram_req_ctrl

Interface
REQ-001 Param TO_CYCLES, default 1024: idle cycles without byte progress before timeout abort.
REQ-002 Param MAX_LEN, default 4096: max bytes per request (downstream TX FIFO depth).
REQ-003 sys_clk in 1: single clock; all logic rising-edge.
REQ-004 glbl_rst in 1: reset, synchronous, active-high.
REQ-005 req_valid in 1 / req_ready out 1 / req_wr in 1 (1=write, 0=read) / req_addr in 16 / req_len in 16 (bytes): host request, accepted when valid&&ready.
REQ-006 wdat_data in 8 / wdat_valid in 1 / wdat_ready out 1: host write-byte stream.
REQ-007 rdat_data out 8 / rdat_valid out 1 / rdat_last out 1: read-byte stream to host, no backpressure.
REQ-008 done out 1 / done_err out 2 / done_sum out 16: completion pulse, status (0 ok, 1 bad length, 2 timeout, 3 framing), byte checksum.
REQ-009 flash_wren out 1 / flash_rden out 1 / flash_addr out 16 / flash_length out 16 / flash_ready in 1: command port to FRAM access stage.
REQ-010 flash_wr_data out 8 / flash_wr_valid out 1 / flash_wr_last out 1: write bytes to FRAM access stage.
REQ-011 flash_rd_data in 8 / flash_rd_valid in 1 / flash_rd_last in 1: read bytes from FRAM access stage.

Function
REQ-012 States: IDLE, ISSUE, WDATA, WWAIT, RDATA, RWAIT, DONE.
REQ-013 req_ready = (state==IDLE) && flash_ready; combinational.
REQ-014 IDLE, accept: latch wr/addr/len; clear byte count, checksum, timeout counter; len==0 or len>MAX_LEN -> DONE with err 1, no downstream activity; else -> ISSUE.
REQ-015 ISSUE: one-cycle registered pulse of flash_wren (wr) or flash_rden (rd) with flash_addr/flash_length = latched values, held stable until next accept; -> WDATA (wr) or RDATA (rd).
REQ-016 WDATA: wdat_ready=1; each handshake registers byte to flash_wr_data with flash_wr_valid=1 next cycle, flash_wr_last=1 on byte len; count++; checksum += byte; after byte len, wdat_ready=0 same cycle, -> WWAIT.
REQ-017 WWAIT: -> DONE (err 0) on first cycle flash_ready==1.
REQ-018 RDATA: each flash_rd_valid: rdat_data=flash_rd_data, rdat_valid=1 one cycle later (1-cycle latency); count++; checksum += byte; rdat_last=1 on byte len; after byte len -> RWAIT.
REQ-019 RDATA framing: flash_rd_last on byte other than len, or missing on byte len -> sticky framing flag; byte still forwarded; final err 3 if no timeout.
REQ-020 RWAIT: -> DONE on flash_ready==1; flash_rd_valid seen here is dropped and sets framing flag.
REQ-021 Timeout counter: clears on every byte moved and on state entry; increments in WDATA/WWAIT/RDATA/RWAIT; reaching TO_CYCLES -> DONE err 2 (priority over framing); wdat_ready deasserts immediately.
REQ-022 DONE: done=1 one cycle with done_err and done_sum (16-bit sum of transferred bytes, mod 2^16); -> IDLE. done_err/done_sum hold until next done.
REQ-023 flash_rd_valid in IDLE/ISSUE/DONE ignored; rdat_valid stays 0.
REQ-024 Simultaneous wdat handshake and timeout expiry: byte is taken, timeout counter clears, no abort.
REQ-025 Count 16-bit (len up to MAX_LEN, no wrap); checksum add wraps silently.

Reset
REQ-026 glbl_rst: state IDLE; flash_wren, flash_rden, flash_wr_valid, flash_wr_last, rdat_valid, rdat_last, done, wdat_ready = 0; flash_addr, flash_length, flash_wr_data, rdat_data, done_err, done_sum, counters = 0.
REQ-027 Reset mid-transfer aborts without done; first accept after release only when flash_ready==1.

Verification
REQ-028 Write addr 0x0100 len 4 bytes 01,02,03,04 -> one flash_wren pulse, flash_length=4, four flash_wr_valid, last on 04; done err 0 sum 0x000A.
REQ-029 Read addr 0x0200 len 3, model returns AA,BB,CC with last on CC -> rdat AA,BB,CC, rdat_last on CC; done err 0 sum 0x0231.
REQ-030 req_len 0 and req_len 4097 -> no flash_wren/rden; done err 1 sum 0.
REQ-031 Write len 2, host sends one byte then stalls TO_CYCLES -> done err 2; wdat_ready 0 thereafter; req_ready returns after flash_ready=1.
REQ-032 Read len 3, model asserts flash_rd_last on byte 2 -> 3 bytes forwarded, done err 3.
REQ-033 glbl_rst mid-read at byte 2 -> all outputs reset values next cycle, no done; new request completes err 0.
